mem_master: RTL

Core-side initiator for the data memory port: accepts single load/store requests from the CPU datapath, drives the memory block's `en`/`write_enable`/`byte_select`/`byte_enable`/`addr`/`data_in` interface, holds the request through `mem_wait` stalls and returns the result. Byte lanes are handled here: byte loads are extracted and zero- or sign-extended, and byte stores are replicated onto both lanes. Misaligned word accesses are rejected, and accesses that stall past a bounded wait time are aborted.

---
 rtl/mem_master_if.sv | 40 ++++
 rtl/mem_master.sv | 122 ++++++++++++
 2 files changed

// File: rtl/mem_master_if.sv
// mem_master_if: groups the core request/response handshake and the memory
// port signals of mem_master.
//   master modport: the mem_master view (drives req_ready, rsp_*, mem_* outs).
//   slave modport : the core + memory view (drives req_*, mem_data_out, mem_wait).
interface mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic        req_signed;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        mem_en;
  logic        mem_write_enable;
  logic        mem_byte_select;
  logic        mem_byte_enable;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic        mem_wait;

  modport master (
    input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
           mem_data_out, mem_wait,
    output req_ready, rsp_valid, rsp_data, rsp_err,
           mem_en, mem_write_enable, mem_byte_select, mem_byte_enable,
           mem_addr, mem_data_in
  );

  modport slave (
    output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
           mem_data_out, mem_wait,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
           mem_en, mem_write_enable, mem_byte_select, mem_byte_enable,
           mem_addr, mem_data_in
  );
endinterface

// File: rtl/mem_master.sv
// mem_master: core-side initiator for the data memory port.
// Accepts one load/store at a time, holds it on the memory port through
// mem_wait stalls, and returns a one-cycle rsp_valid pulse with the result.
// Byte loads are lane-extracted and zero/sign-extended; byte stores are
// replicated onto both lanes. Misaligned word accesses and accesses stalled
// for TIMEOUT consecutive cycles complete with rsp_err.
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset
//   bus     - mem_master_if.master: req_* in, req_ready/rsp_* out,
//             mem_* to/from the memory block
// Parameter:
//   TIMEOUT - max consecutive mem_wait cycles before abort (1..65535)
module mem_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  mem_master_if.master  bus
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] cnt_inc;
  logic          sign_q;
  logic [7:0]    lane;
  logic [15:0]   load_res;

  always_comb begin
    cnt_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + CW'(1);
  end

  // Result formed from the registered access attributes, which are held
  // constant for the whole access.
  always_comb begin
    lane     = bus.mem_byte_select ? bus.mem_data_out[15:8] : bus.mem_data_out[7:0];
    load_res = bus.mem_data_out;
    if (bus.mem_write_enable) begin
      load_res = '0;
    end else if (bus.mem_byte_enable) begin
      load_res = {{8{sign_q & lane[7]}}, lane};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      wait_cnt             <= '0;
      sign_q               <= 1'b0;
      bus.req_ready        <= 1'b1;
      bus.rsp_valid        <= 1'b0;
      bus.rsp_data         <= '0;
      bus.rsp_err          <= 1'b0;
      bus.mem_en           <= 1'b0;
      bus.mem_write_enable <= 1'b0;
      bus.mem_byte_select  <= 1'b0;
      bus.mem_byte_enable  <= 1'b0;
      bus.mem_addr         <= '0;
      bus.mem_data_in      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            if (!bus.req_byte && bus.req_addr[0]) begin
              // Misaligned word access: respond immediately, no memory cycle.
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_data  <= '0;
            end else begin
              state                <= ACCESS;
              wait_cnt             <= '0;
              sign_q               <= bus.req_signed;
              bus.mem_en           <= 1'b1;
              bus.mem_write_enable <= bus.req_write;
              bus.mem_byte_select  <= bus.req_addr[0];
              bus.mem_byte_enable  <= bus.req_byte;
              bus.mem_addr         <= bus.req_addr;
              bus.mem_data_in      <= bus.req_byte ? {bus.req_wdata[7:0], bus.req_wdata[7:0]}
                                                   : bus.req_wdata;
            end
          end
        end
        ACCESS: begin
          if (!bus.mem_wait) begin
            state         <= RESP;
            bus.mem_en    <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_data  <= load_res;
          end else begin
            wait_cnt <= cnt_inc;
            if (cnt_inc == CW'(TIMEOUT)) begin
              state         <= RESP;
              bus.mem_en    <= 1'b0;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_data  <= '0;
            end
          end
        end
        RESP: begin
          state         <= IDLE;
          wait_cnt      <= '0;
          bus.rsp_valid <= 1'b0;
          bus.req_ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
